// File: rtl/btn_sched_pkg.sv
// Shared widths and types for the button event scheduler.
// Default sizing: four buttons, two-bit event id, eight-bit drop counter.
package btn_sched_pkg;
  localparam int N_BTN_DEF  = 4;
  localparam int ID_W_DEF   = $clog2(N_BTN_DEF);
  localparam int DROP_W_DEF = 8;

  typedef logic [ID_W_DEF-1:0]  btn_id_t;
  typedef logic [N_BTN_DEF-1:0] btn_mask_t;
endpackage

// File: rtl/btn_event_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
// Produces a one-hot grant, the granted index and an any-grant flag.
module rr_arbiter
  import btn_sched_pkg::*;
#(
  parameter int N_BTN = N_BTN_DEF,
  parameter int ID_W  = $clog2(N_BTN)
) (
  input  logic [N_BTN-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_BTN-1:0] o_grant_oh,
  output logic [ID_W-1:0]  o_grant_id,
  output logic             o_any_grant
);

  int w_idx;

  always_comb begin
    o_grant_oh  = '0;
    o_grant_id  = '0;
    o_any_grant = 1'b0;
    w_idx       = 0;
    for (int k = 0; k < N_BTN; k++) begin
      w_idx = (int'(i_ptr) + k) % N_BTN;
      if (!o_any_grant && i_req[w_idx]) begin
        o_any_grant       = 1'b1;
        o_grant_oh[w_idx] = 1'b1;
        o_grant_id        = ID_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/btn_event_scheduler.sv
// Queues one pending event per button and issues them round-robin over valid/ready.
// Define BTN_DROP_CNT_EN to add the o_drop_cnt port and its saturating counter.
module btn_event_scheduler
  import btn_sched_pkg::*;
#(
  parameter int N_BTN  = N_BTN_DEF,
  parameter int ID_W   = $clog2(N_BTN)
`ifdef BTN_DROP_CNT_EN
  , parameter int DROP_W = DROP_W_DEF
`endif
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic [N_BTN-1:0] i_btn_pulse,
  output logic             o_ev_valid,
  input  logic             i_ev_ready,
  output logic [ID_W-1:0]  o_ev_id,
  output logic [N_BTN-1:0] o_pending
`ifdef BTN_DROP_CNT_EN
  , output logic [DROP_W-1:0] o_drop_cnt
`endif
);

  logic [N_BTN-1:0] r_pending;
  logic [ID_W-1:0]  r_ptr;
  logic             r_ev_valid;
  logic [ID_W-1:0]  r_ev_id;

  logic [N_BTN-1:0] w_grant_oh;
  logic [ID_W-1:0]  w_grant_id;
  logic             w_any_grant;
  logic             w_load;
  logic [N_BTN-1:0] w_clr;
  logic [ID_W-1:0]  w_ptr_nxt;

  rr_arbiter #(.N_BTN(N_BTN), .ID_W(ID_W)) u_arb (
    .i_req       (r_pending),
    .i_ptr       (r_ptr),
    .o_grant_oh  (w_grant_oh),
    .o_grant_id  (w_grant_id),
    .o_any_grant (w_any_grant)
  );

  assign w_load    = (!r_ev_valid || i_ev_ready) && i_enable && w_any_grant;
  assign w_clr     = w_load ? w_grant_oh : '0;
  assign w_ptr_nxt = (w_grant_id == ID_W'(N_BTN - 1)) ? '0 : w_grant_id + 1'b1;

  // A pulse on the bit being granted this cycle re-queues instead of dropping.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pending <= '0;
    end else if (!i_enable) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | i_btn_pulse;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ev_valid <= 1'b0;
      r_ev_id    <= '0;
      r_ptr      <= '0;
    end else if (w_load) begin
      r_ev_valid <= 1'b1;
      r_ev_id    <= w_grant_id;
      r_ptr      <= w_ptr_nxt;
    end else if (r_ev_valid && i_ev_ready) begin
      r_ev_valid <= 1'b0;
    end
  end

  assign o_ev_valid = r_ev_valid;
  assign o_ev_id    = r_ev_id;
  assign o_pending  = r_pending;

`ifdef BTN_DROP_CNT_EN
  logic [N_BTN-1:0]  w_drop_vec;
  logic [DROP_W:0]   w_drop_sum;
  logic [DROP_W-1:0] r_drop_cnt;

  assign w_drop_vec = i_enable ? (i_btn_pulse & r_pending & ~w_clr) : '0;

  // Every dropped pulse counts, even several in one cycle; the sum saturates.
  always_comb begin
    w_drop_sum = {1'b0, r_drop_cnt};
    for (int i = 0; i < N_BTN; i++) begin
      w_drop_sum = w_drop_sum + (DROP_W + 1)'(w_drop_vec[i]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_drop_cnt <= '0;
    end else if (w_drop_sum[DROP_W]) begin
      r_drop_cnt <= '1;
    end else begin
      r_drop_cnt <= w_drop_sum[DROP_W-1:0];
    end
  end

  assign o_drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_btn_event_scheduler.sv
// Scoreboard bench for btn_event_scheduler: expected ids queued at stimulus time,
// popped by a monitor on each accepted event; drop counter checks need BTN_DROP_CNT_EN.
module tb_btn_event_scheduler;
  import btn_sched_pkg::*;

  logic      clk = 1'b0;
  logic      reset;
  logic      enable;
  btn_mask_t btn_pulse;
  logic      ev_valid;
  logic      ev_ready;
  btn_id_t   ev_id;
  btn_mask_t pending;
`ifdef BTN_DROP_CNT_EN
  logic [DROP_W_DEF-1:0] drop_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  btn_event_scheduler dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_enable    (enable),
    .i_btn_pulse (btn_pulse),
    .o_ev_valid  (ev_valid),
    .i_ev_ready  (ev_ready),
    .o_ev_id     (ev_id),
    .o_pending   (pending)
`ifdef BTN_DROP_CNT_EN
    , .o_drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick(1);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic chk_drop(input string name, input int exp);
`ifdef BTN_DROP_CNT_EN
    chk(name, int'(drop_cnt), exp);
`endif
  endtask

  // Monitor: an accepted event is one presenting valid with ready before the edge.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (ev_valid && ev_ready && !reset) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got id %0d expected none (t=%0t)", ev_id, $time);
        end else begin
          e = exp_q.pop_front();
          if (int'(ev_id) != e) begin
            errors++;
            $display("FAIL event_id: got %0d expected %0d (t=%0t)", ev_id, e, $time);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b1; btn_pulse = '0; ev_ready = 1'b1;
    tick(3);
    reset = 1'b0;
    chk("rst_valid", int'(ev_valid), 0);
    chk("rst_id", int'(ev_id), 0);
    chk("rst_pending", int'(pending), 0);
    chk_drop("rst_drop", 0);
    tick(5);

    // 1: single pulse, minimum latency
    btn_pulse = 4'b0100; exp_q.push_back(2);
    tick(1); btn_pulse = '0;
    chk("t1_pending_set", int'(pending), 4'b0100);
    chk("t1_valid_early", int'(ev_valid), 0);
    tick(1);
    chk("t1_valid", int'(ev_valid), 1);
    chk("t1_id", int'(ev_id), 2);
    chk("t1_pending_clr", int'(pending), 0);
    tick(1);
    chk("t1_valid_drop", int'(ev_valid), 0);
    chk("t1_id_hold", int'(ev_id), 2);

    // 2: simultaneous pulses, rr from ptr 0
    do_reset();
    btn_pulse = 4'b1011;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
    tick(1); btn_pulse = '0;
    tick(1); chk("t2_id0", int'(ev_id), 0); chk("t2_v0", int'(ev_valid), 1);
    tick(1); chk("t2_id1", int'(ev_id), 1);
    tick(1); chk("t2_id2", int'(ev_id), 3); chk("t2_pend", int'(pending), 0);
    tick(1); chk("t2_idle", int'(ev_valid), 0);
    btn_pulse = 4'b1111;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    tick(1); btn_pulse = '0;
    drain();

    // 3: stalled consumer, repeat pulse on a pending button is dropped
    do_reset();
    ev_ready = 1'b0;
    btn_pulse = 4'b0001; exp_q.push_back(0);
    tick(1); btn_pulse = '0;
    tick(1);
    chk("t3_v", int'(ev_valid), 1); chk("t3_id", int'(ev_id), 0);
    btn_pulse = 4'b0010; exp_q.push_back(1);
    tick(1); btn_pulse = '0;
    chk("t3_pend", int'(pending), 4'b0010);
    tick(4);
    btn_pulse = 4'b0010;
    tick(1); btn_pulse = '0;
    chk("t3_pend2", int'(pending), 4'b0010);
    chk("t3_stall_id", int'(ev_id), 0);
    chk_drop("t3_drop", 1);
    ev_ready = 1'b1;
    drain();
    tick(2);
    chk("t3_idle", int'(ev_valid), 0);

    // 4: all buttons pulsing every cycle, fair rotation
    do_reset();
    for (int i = 0; i < 11; i++) exp_q.push_back(i % 4);
    for (int i = 0; i < 8; i++) begin
      btn_pulse = 4'b1111;
      tick(1);
    end
    btn_pulse = '0;
    drain();
    chk_drop("t4_drop", 21);

    // 5: disable flushes pending, held event survives, ptr kept
    do_reset();
    ev_ready = 1'b0;
    btn_pulse = 4'b0111; exp_q.push_back(0);
    tick(1); btn_pulse = '0;
    tick(1);
    chk("t5_v", int'(ev_valid), 1); chk("t5_id", int'(ev_id), 0);
    chk("t5_pend", int'(pending), 4'b0110);
    enable = 1'b0; btn_pulse = 4'b0110;
    tick(1); btn_pulse = '0;
    chk("t5_flush", int'(pending), 0);
    chk("t5_hold_v", int'(ev_valid), 1);
    chk_drop("t5_nodrop", 0);
    tick(3);
    ev_ready = 1'b1;
    drain();
    tick(3);
    chk("t5_idle", int'(ev_valid), 0);
    chk("t5_idle_pend", int'(pending), 0);
    enable = 1'b1;
    btn_pulse = 4'b1111;
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(0);
    tick(1); btn_pulse = '0;
    drain();

    // 6: reset discards a valid unaccepted event
    do_reset();
    ev_ready = 1'b0;
    btn_pulse = 4'b1000;
    tick(1); btn_pulse = '0;
    tick(1);
    chk("t6_v", int'(ev_valid), 1); chk("t6_id", int'(ev_id), 3);
    btn_pulse = 4'b1000; tick(1);
    btn_pulse = 4'b1000; tick(1);
    btn_pulse = '0;
    chk_drop("t6_drop", 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("t6_v_rst", int'(ev_valid), 0);
    chk("t6_id_rst", int'(ev_id), 0);
    chk("t6_pend_rst", int'(pending), 0);
    chk_drop("t6_drop_rst", 0);
    tick(3);
    chk("t6_idle", int'(ev_valid), 0);
    chk("final_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
